muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2, operation select: 00 MUL (low 32 bits), 01 MULHU (high 32 bits, unsigned), 10 DIVU, 11 REMU.
REQ-006 SHALL have ports a and b, input, 32 each, unsigned operands (a = multiplicand/dividend, b = multiplier/divisor).
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have port result, output, 32, result of the last completed operation; held until the next done.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 IDLE with start=1 SHALL latch a, b and op, clear the step counter, and enter RUN.
REQ-012 RUN SHALL execute one iteration per cycle for exactly WIDTH cycles, then enter DONE.
REQ-013 DONE SHALL load result, assert done for one cycle, and return to IDLE.
REQ-014 busy SHALL be 1 in RUN and DONE and 0 in IDLE; done SHALL be 1 only in DONE.
REQ-015 Latency SHALL be fixed: done is high in cycle WIDTH+1 after the start-accepting edge (33 for WIDTH=32).
REQ-016 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-017 op, a and b SHALL be ignored after capture; input changes during RUN do not affect the result.
REQ-018 Multiply SHALL use shift-add on a 64-bit {hi,lo} register.
REQ-019 Each multiply step: if lo[0] is 1, hi = hi + multiplicand; then the 65-bit {carry,hi,lo} shifts right by 1.
REQ-020 The multiply carry SHALL be derived as (sum < hi_before), unsigned.
REQ-021 Divide SHALL be restoring division.
REQ-022 Each divide step: rem = {rem[30:0], quotient MSB}; trial = rem - b; if {1'b0,rem} >= {1'b0,b} unsigned, rem = trial and the quotient bit is 1, else the quotient bit is 0.
REQ-023 All add/sub SHALL be performed by one shared alu instance (alucontrol 000 add, 001 sub); the alu's zero output SHALL be unused.
REQ-024 DIVU with b=0 SHALL return 0xFFFFFFFF; REMU with b=0 SHALL return a; this requires no special case in the iterative path.
REQ-025 A new start SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-026 reset SHALL force, asynchronously: state IDLE, busy 0, done 0, result 0, counter 0, internal registers 0.
REQ-027 reset during RUN or DONE SHALL abort the operation with no done pulse; the next start SHALL behave as if from power-up.

Configuration
REQ-028 With MULDIV_ZERO_FAST_EN defined, DIVU/REMU with captured b=0 SHALL skip RUN and go IDLE->DONE, giving done 1 cycle after start with the REQ-024 values.
REQ-029 Without MULDIV_ZERO_FAST_EN, divide-by-zero SHALL take the full WIDTH+1 latency.

Structure
REQ-030 The shared package muldiv_pkg SHALL hold: the op encoding enum (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU), the FSM state enum, and localparams ALU_ADD=3'b000 and ALU_SUB=3'b001.
REQ-031 The only sub-module SHALL be one instance of the core alu; FSM, counter and shift registers SHALL be inline.

Verification
REQ-032 Test: MUL a=7, b=6 -> result 0x0000002A, done exactly 33 cycles after start, busy high for cycles 1-33.
REQ-033 Test: a=b=0xFFFFFFFF -> MUL 0x00000001; MULHU 0xFFFFFFFE.
REQ-034 Test: DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; DIVU 5/9 -> 0, REMU 5/9 -> 5.
REQ-035 Test: b=0 -> DIVU 0xFFFFFFFF, REMU a=5 gives 5; done at cycle 33 without the macro, cycle 1 with MULDIV_ZERO_FAST_EN.
REQ-036 Test: start pulsed at cycle 10 of RUN with different operands -> ignored, and the original result is unchanged.
REQ-037 Test: reset asserted mid-RUN -> busy/done/result 0 immediately without waiting for clk, no done pulse; a following MUL 3*4 -> 12.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the sequential multiply/divide unit: op encoding, FSM states,
// ALU control codes and the final result selection.
`timescale 1ns/1ps
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Multiply leaves {hi,lo} as the product; divide leaves hi = remainder, lo = quotient.
    function automatic logic [31:0] select_result(input op_e op, input logic [31:0] hi,
                                                  input logic [31:0] lo);
        logic [31:0] sel;
        case (op)
            OP_MUL:   sel = lo;
            OP_MULHU: sel = hi;
            OP_DIVU:  sel = lo;
            default:  sel = hi;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/muldiv_seq_alu.sv
// Core integer ALU; the multiply/divide unit routes every add and subtract through it.
`timescale 1ns/1ps
module muldiv_seq_alu
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucontrol,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // NOTE: every path assigns result, so this always_comb cannot infer a latch.
    always_comb begin
        case (alucontrol)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            3'b010:  result = a & b;
            3'b011:  result = a | b;
            3'b101:  result = {{(WIDTH-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32-cycle unsigned multiply (shift-add) / divide (restoring) unit.
// Optional macro MULDIV_ZERO_FAST_EN: divide by zero skips RUN and completes in one cycle.
`timescale 1ns/1ps
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  result_q, result_d;

    logic              is_mul;
    logic [WIDTH-1:0]  rem_sh;
    logic [WIDTH-1:0]  alu_a, alu_y;
    logic [2:0]        alu_ctl;
    logic              carry, div_ge;
    logic [WIDTH-1:0]  step_hi, step_lo;

    // Multiply: opnd = multiplicand, lo = multiplier. Divide: opnd = divisor, lo = dividend/quotient.
    assign is_mul  = (op_q == OP_MUL) || (op_q == OP_MULHU);
    assign rem_sh  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign alu_a   = is_mul ? hi_q : rem_sh;
    assign alu_ctl = is_mul ? ALU_ADD : ALU_SUB;

    muldiv_seq_alu #(.WIDTH(WIDTH)) u_alu (
        .a          (alu_a),
        .b          (opnd_q),
        .alucontrol (alu_ctl),
        .result     (alu_y),
        .zero       ()
    );

    assign carry  = (alu_y < hi_q);
    assign div_ge = ({1'b0, rem_sh} >= {1'b0, opnd_q});

    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        if (is_mul) begin
            if (lo_q[0]) begin
                step_hi = {carry, alu_y[WIDTH-1:1]};
                step_lo = {alu_y[0], lo_q[WIDTH-1:1]};
            end else begin
                step_hi = {1'b0, hi_q[WIDTH-1:1]};
                step_lo = {hi_q[0], lo_q[WIDTH-1:1]};
            end
        end else begin
            step_hi = div_ge ? alu_y : rem_sh;
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    cnt_d   = '0;
                    hi_d    = '0;
                    state_d = RUN;
                    if (op_e'(op) == OP_MUL || op_e'(op) == OP_MULHU) begin
                        opnd_d = a;
                        lo_d   = b;
                    end else begin
                        opnd_d = b;
                        lo_d   = a;
                    end
`ifdef MULDIV_ZERO_FAST_EN
                    // The iterative path would end with rem = a, quotient = all ones anyway.
                    if (op[1] && b == '0) begin
                        hi_d     = a;
                        lo_d     = '1;
                        result_d = select_result(op_e'(op), a, '1);
                        state_d  = DONE;
                    end
`endif
                end
            end
            RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = select_result(op_q, step_hi, step_lo);
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int LAT = 33;
`ifdef MULDIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        busy, done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op_i),
        .a      (a_i),
        .b      (b_i),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Issue one operation from a falling edge in IDLE; report latency, result and
    // whether busy stayed high until done and dropped the cycle after with result held.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_k, output int lat, output logic [31:0] res,
                          output bit busy_ok, output bit idle_ok);
        lat     = -1;
        res     = 32'hDEAD_BEEF;
        busy_ok = 1'b1;
        op_i = op; a_i = a; b_i = b; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (inj_k != 0 && k == inj_k) begin
                start = 1'b1; op_i = ~op; a_i = 32'h1234_5678; b_i = 32'h0000_0003;
            end
            if (inj_k != 0 && k == inj_k + 1) start = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                res = result;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        idle_ok = (busy === 1'b0) && (done === 1'b0) && (result === res);
    endtask

    int          lat;
    logic [31:0] res;
    bit          busy_ok, idle_ok;

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
        #3;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b result=%h exp 0/0/00000000", busy, done, result);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mul();
        run_op(OP_MUL, 32'd7, 32'd6, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_002A) begin
            failures++; $display("FAIL mul_7x6_result got=%h exp=0000002a", res);
        end
        checks++;
        if (lat !== LAT) begin
            failures++; $display("FAIL mul_7x6_latency got=%0d exp=%0d", lat, LAT);
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            failures++; $display("FAIL mul_7x6_busy got=low_in_run exp=high_cycles_1_to_33");
        end
        checks++;
        if (idle_ok !== 1'b1) begin
            failures++; $display("FAIL mul_7x6_after_done got busy=%b done=%b result=%h exp 0/0/0000002a", busy, done, result);
        end
    endtask

    task automatic test_mul_max();
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_0001 || lat !== LAT) begin
            failures++; $display("FAIL mul_max got=%h lat=%0d exp=00000001 lat=%0d", res, lat, LAT);
        end
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'hFFFF_FFFE || lat !== LAT) begin
            failures++; $display("FAIL mulhu_max got=%h lat=%0d exp=fffffffe lat=%0d", res, lat, LAT);
        end
    endtask

    task automatic test_div();
        run_op(OP_DIVU, 32'd100, 32'd7, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_000E || lat !== LAT) begin
            failures++; $display("FAIL divu_100_7 got=%h lat=%0d exp=0000000e lat=%0d", res, lat, LAT);
        end
        run_op(OP_REMU, 32'd100, 32'd7, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_0002) begin
            failures++; $display("FAIL remu_100_7 got=%h exp=00000002", res);
        end
        run_op(OP_DIVU, 32'd5, 32'd9, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_0000) begin
            failures++; $display("FAIL divu_5_9 got=%h exp=00000000", res);
        end
        run_op(OP_REMU, 32'd5, 32'd9, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_0005 || idle_ok !== 1'b1) begin
            failures++; $display("FAIL remu_5_9 got=%h idle_ok=%b exp=00000005 idle_ok=1", res, idle_ok);
        end
    endtask

    task automatic test_div_zero();
        run_op(OP_DIVU, 32'd5, 32'd0, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL divu_by_zero_result got=%h exp=ffffffff", res);
        end
        checks++;
        if (lat !== ZLAT) begin
            failures++; $display("FAIL divu_by_zero_latency got=%0d exp=%0d", lat, ZLAT);
        end
        run_op(OP_REMU, 32'd5, 32'd0, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_0005 || lat !== ZLAT) begin
            failures++; $display("FAIL remu_by_zero got=%h lat=%0d exp=00000005 lat=%0d", res, lat, ZLAT);
        end
    endtask

    task automatic test_ignore_start();
        run_op(OP_MUL, 32'd7, 32'd6, 10, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_002A || lat !== LAT) begin
            failures++; $display("FAIL ignore_start_result got=%h lat=%0d exp=0000002a lat=%0d", res, lat, LAT);
        end
        checks++;
        if (idle_ok !== 1'b1) begin
            failures++; $display("FAIL ignore_start_queued got busy=%b result=%h exp busy=0 result=0000002a", busy, result);
        end
    endtask

    task automatic test_back_to_back();
        run_op(OP_MULHU, 32'h8000_0000, 32'd4, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_0002) begin
            failures++; $display("FAIL b2b_first got=%h exp=00000002", res);
        end
        run_op(OP_DIVU, 32'd1000, 32'd10, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_0064 || lat !== LAT || busy_ok !== 1'b1) begin
            failures++; $display("FAIL b2b_second got=%h lat=%0d busy_ok=%b exp=00000064 lat=%0d busy_ok=1", res, lat, busy_ok, LAT);
        end
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        saw_done = 1'b0;
        op_i = OP_MUL; a_i = 32'hFFFF_FFFF; b_i = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failures++; $display("FAIL reset_mid_run got busy=%b done=%b result=%h exp 0/0/00000000", busy, done, result);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++; $display("FAIL reset_abort got=activity_after_reset exp=idle_no_done");
        end
        run_op(OP_MUL, 32'd3, 32'd4, 0, lat, res, busy_ok, idle_ok);
        checks++;
        if (res !== 32'h0000_000C || lat !== LAT) begin
            failures++; $display("FAIL mul_after_reset got=%h lat=%0d exp=0000000c lat=%0d", res, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_max();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
